// File: rtl/fdce_ff.sv
// fdce_ff: WIDTH-bit D flip-flop with clock enable, asynchronous clear,
// parameter-selected capture edge and optional data inversion.  Rev 1.0
`default_nettype none

module fdce_ff #(
   parameter int WIDTH         = 1,
   parameter     INIT          = 1'b0,
   parameter bit IS_C_INVERTED = 1'b0,
   parameter bit IS_D_INVERTED = 1'b0
) (
   input  wire logic             C,
   input  wire logic             CLR,
   input  wire logic             CE,
   input  wire logic [WIDTH-1:0] D,
   output logic      [WIDTH-1:0] Q
);

   // A one-bit INIT is replicated across the word; otherwise it must match WIDTH.
   localparam logic [WIDTH-1:0] c_init_vec =
      ($bits(INIT) == 1) ? {WIDTH{1'(INIT)}} : WIDTH'(INIT);

   if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
      $fatal(1, "fdce_ff: WIDTH=%0d outside 1..64", WIDTH);
   end

   if (($bits(INIT) != 1) && ($bits(INIT) != WIDTH)) begin : g_bad_init
      $fatal(1, "fdce_ff: INIT is %0d bits, expected 1 or %0d", $bits(INIT), WIDTH);
   end

   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] r_q = c_init_vec;

   assign w_d = IS_D_INVERTED ? ~D : D;

   // The ternary hold merges per bit, so an unknown CE only disturbs bits where D and Q differ.
   if (IS_C_INVERTED) begin : g_fall_edge
      always_ff @(negedge C or posedge CLR) begin
         if (CLR) begin
            r_q <= '0;
         end else begin
            r_q <= CE ? w_d : r_q;
         end
      end
   end else begin : g_rise_edge
      always_ff @(posedge C or posedge CLR) begin
         if (CLR) begin
            r_q <= '0;
         end else begin
            r_q <= CE ? w_d : r_q;
         end
      end
   end

   assign Q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_fdce_ff.sv
// tb_fdce_ff: three fdce_ff configurations driven by directed and random
// stimulus, checked every sample cycle against an event-level model.
`default_nettype none

module tb_fdce_ff;

   logic       C   = 1'b0;
   logic       CLR = 1'b0;
   logic       CE  = 1'b0;
   logic       D1  = 1'b0;
   logic [7:0] D8  = 8'h00;
   logic [7:0] DI  = 8'h00;
   logic       Q1;
   logic [7:0] Q8;
   logic [7:0] QI;

   logic clk_s = 1'b0;
   always #5 clk_s = ~clk_s;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: what each flop must hold, from power-up values onward.
   logic       m_q1   = 1'b1;
   logic [7:0] m_q8   = 8'h00;
   logic [7:0] m_qi   = 8'h5A;
   logic       prev_c = 1'b0;

   fdce_ff #(.WIDTH(1), .INIT(1'b1)) u_w1 (
      .C(C), .CLR(CLR), .CE(CE), .D(D1), .Q(Q1)
   );

   fdce_ff #(.WIDTH(8)) u_w8 (
      .C(C), .CLR(CLR), .CE(CE), .D(D8), .Q(Q8)
   );

   fdce_ff #(.WIDTH(8), .INIT(8'h5A), .IS_C_INVERTED(1'b1), .IS_D_INVERTED(1'b1)) u_inv (
      .C(C), .CLR(CLR), .CE(CE), .D(DI), .Q(QI)
   );

   task automatic model_update();
      if (CLR) begin
         m_q1 = 1'b0;
         m_q8 = 8'h00;
         m_qi = 8'h00;
      end else begin
         if (!prev_c && C && CE) begin
            m_q1 = D1;
            m_q8 = D8;
         end
         if (prev_c && !C && CE) begin
            m_qi = ~DI;
         end
      end
      prev_c = C;
   endtask

   task automatic set_c(input logic v);
      @(negedge clk_s);
      C = v;
      model_update();
   endtask

   task automatic set_clr(input logic v);
      @(negedge clk_s);
      CLR = v;
      model_update();
   endtask

   task automatic set_data(input logic ce, input logic d1, input logic [7:0] d8, input logic [7:0] di);
      @(negedge clk_s);
      CE = ce;
      D1 = d1;
      D8 = d8;
      DI = di;
      model_update();
   endtask

   task automatic clr_and_rise();
      @(negedge clk_s);
      CLR = 1'b1;
      C   = 1'b1;
      model_update();
   endtask

   task automatic probe();
      @(posedge clk_s);
      #1;
   endtask

   task automatic check_lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk_s) begin
      vectors += 3;
      if (Q1 !== m_q1) begin
         miscompares++;
         $display("FAIL cmp_w1 t=%0t got=%b expected=%b", $time, Q1, m_q1);
      end
      if (Q8 !== m_q8) begin
         miscompares++;
         $display("FAIL cmp_w8 t=%0t got=%h expected=%h", $time, Q8, m_q8);
      end
      if (QI !== m_qi) begin
         miscompares++;
         $display("FAIL cmp_inv t=%0t got=%h expected=%h", $time, QI, m_qi);
      end
   end

   initial begin
      // Power-up values before any clear or edge
      probe();
      check_lit("pwrup_w1", {7'b0, Q1}, 8'h01);
      check_lit("pwrup_w8", Q8, 8'h00);
      check_lit("pwrup_inv", QI, 8'h5A);
      check_lit("model_pwrup_w1", {7'b0, m_q1}, 8'h01);

      // 10 ns clear pulse with C idle
      set_clr(1'b1);
      probe();
      check_lit("clr_noclk_w1", {7'b0, Q1}, 8'h00);
      check_lit("clr_noclk_inv", QI, 8'h00);
      set_clr(1'b0);

      set_data(1'b1, 1'b1, 8'hA5, 8'h00);
      set_c(1'b1);
      probe();
      check_lit("load_w1", {7'b0, Q1}, 8'h01);
      check_lit("load_w8", Q8, 8'hA5);
      set_c(1'b0);
      probe();
      check_lit("inv_fall_load", QI, 8'hFF);

      set_data(1'b0, 1'b0, 8'h3C, 8'h00);
      for (int i = 0; i < 3; i++) begin
         set_c(1'b1);
         set_c(1'b0);
      end
      probe();
      check_lit("hold_w1", {7'b0, Q1}, 8'h01);
      check_lit("hold_w8", Q8, 8'hA5);

      set_data(1'b1, 1'b0, 8'h3C, 8'h00);
      set_c(1'b1);
      probe();
      check_lit("load2_w8", Q8, 8'h3C);
      check_lit("model_load2_w8", m_q8, 8'h3C);
      set_c(1'b0);
      set_clr(1'b1);
      probe();
      check_lit("clr_w8", Q8, 8'h00);
      set_clr(1'b0);

      // Clear rising together with a capture edge, then held across edges
      set_data(1'b1, 1'b1, 8'hFF, 8'h00);
      clr_and_rise();
      probe();
      check_lit("clr_coincident_w1", {7'b0, Q1}, 8'h00);
      set_c(1'b0);
      for (int i = 0; i < 2; i++) begin
         set_c(1'b1);
         set_c(1'b0);
      end
      probe();
      check_lit("clr_held_w1", {7'b0, Q1}, 8'h00);
      check_lit("clr_held_w8", Q8, 8'h00);
      set_clr(1'b0);
      probe();
      check_lit("clr_release_noedge_w1", {7'b0, Q1}, 8'h00);
      set_c(1'b1);
      probe();
      check_lit("after_release_w1", {7'b0, Q1}, 8'h01);
      set_c(1'b0);

      // Falling-edge capture with inverted data
      set_clr(1'b1);
      set_clr(1'b0);
      set_data(1'b1, 1'b1, 8'h00, 8'h00);
      set_c(1'b1);
      probe();
      check_lit("inv_rise_nochange", QI, 8'h00);
      set_c(1'b0);
      probe();
      check_lit("inv_fall_capture", QI, 8'hFF);

      // Pulse-latch: single C pulse, long hold on the sample clock, then clear
      set_clr(1'b1);
      set_clr(1'b0);
      set_data(1'b1, 1'b1, 8'h00, 8'h00);
      set_c(1'b1);
      set_c(1'b0);
      repeat (4000) @(negedge clk_s);
      probe();
      check_lit("pulse_latch_hold_w1", {7'b0, Q1}, 8'h01);
      set_clr(1'b1);
      probe();
      check_lit("pulse_latch_clr_w1", {7'b0, Q1}, 8'h00);
      set_clr(1'b0);

      for (int n = 0; n < 600; n++) begin
         int unsigned r;
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            set_c(~C);
         end else if (r <= 6) begin
            set_data(($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
         end else if (r == 7) begin
            set_clr(~CLR);
         end else if (r == 8) begin
            if (!CLR && !C) clr_and_rise();
            else set_c(~C);
         end else begin
            @(negedge clk_s);
         end
      end
      set_clr(1'b0);
      probe();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fdce_ff.md
FDCE_FF -- requirements
Module: fdce_ff

Interface
REQ-001 Parameter WIDTH, default 1: bit width of D and Q (legal range 1..64).
REQ-002 Parameter INIT, default 1'b0 (replicated to WIDTH bits): power-up value of Q.
REQ-003 Parameter IS_C_INVERTED, default 1'b0: 1 selects falling-edge capture on C.
REQ-004 Parameter IS_D_INVERTED, default 1'b0: 1 captures ~D instead of D.
REQ-005 C  input  1  clock; sole clock; capture edge rising (falling when IS_C_INVERTED=1).
REQ-006 CLR  input  1  reset; asynchronous, active-high clear.
REQ-007 CE  input  1  clock enable; active-high.
REQ-008 D  input  WIDTH  data input.
REQ-009 Q  output  WIDTH  registered data output.

Function
REQ-010 On each capture edge of C with CLR=0 and CE=1, Q SHALL take D (or ~D when IS_D_INVERTED=1); latency one capture edge.
REQ-011 On a capture edge with CLR=0 and CE=0, Q SHALL hold its value.
REQ-012 Q SHALL change only on a capture edge of C or on CLR assertion; no combinational path from D or CE to Q.
REQ-013 CLR asserted SHALL force Q to all-zeros immediately, independent of C, CE, D and INIT.
REQ-014 While CLR=1, capture edges SHALL be ignored and Q SHALL stay zero.
REQ-015 CLR SHALL have priority over a simultaneous capture edge: Q is zero.
REQ-016 After CLR deasserts, the first capture edge with CE=1 SHALL load D; until then Q stays zero.
REQ-017 At power-up (time zero, before any CLR or edge) Q SHALL equal INIT.
REQ-018 All WIDTH bits SHALL share C, CE and CLR; bits are otherwise independent.
REQ-019 CE or D unknown (X) at a capture edge SHALL drive X only onto affected bits of Q in simulation; CLR=1 overrides X.
REQ-020 Held-high D=1, CE=1 use (pulse latch) SHALL set Q=1 on the first capture edge and keep it until CLR.

Reset
REQ-021 Reset value of Q SHALL be all-zeros; INIT applies only at power-up.
REQ-022 Reset assertion SHALL be asynchronous; deassertion SHALL be synchronized by the user; no internal synchronizer.
REQ-023 Reset mid-operation SHALL discard the held value without any pending-load state.

Structure
REQ-024 Single module, no sub-modules; one always block sensitive to capture edge and posedge CLR.
REQ-025 Clock inversion SHALL be implemented by parameter-selected edge, not a gated or derived clock.
REQ-026 No shared package needed; parameters are local to the module.
REQ-027 Parameter legality (WIDTH range, INIT width) SHALL be checked at elaboration with a fatal error.
REQ-028 Synthesis SHALL map each bit to one clock-enable, async-clear flip-flop.

Verification
REQ-029 Power-up, INIT=1, WIDTH=1, no edges -> Q=1; then CLR pulse 10 ns -> Q=0 within the pulse, no clock edge needed.
REQ-030 CLR=0, CE=1, D=1, rising C -> Q=1 after that edge; D=0, CE=0, 3 edges -> Q stays 1.
REQ-031 WIDTH=8, CE=1, D=8'hA5 edge then D=8'h3C edge -> Q=8'hA5 then 8'h3C; CLR -> 8'h00.
REQ-032 CLR rising coincident with C edge, D=1, CE=1 -> Q=0; CLR held 2 edges -> Q=0; release, next edge -> Q=1.
REQ-033 IS_C_INVERTED=1, IS_D_INVERTED=1, D=0, CE=1 -> Q=1 only after the falling edge of C, unchanged on rising edges.
REQ-034 Pulse-latch use: D=1, CE=1, single 1-cycle C pulse -> Q=1 held 4000 cycles of an unrelated clock until CLR -> Q=0.
